// File: rtl/rc_drive_mixer.sv
// Arcade mixer for an RC ground vehicle: throttle/steer become left/right PWM widths,
// gated by an arm/failsafe state machine and a rate limiter that snaps to neutral on signal loss.
module rc_drive_mixer #(
   parameter int SLEW_DIV     = 255,
   parameter int SLEW_STEP    = 4,
   parameter int ARM_HOLD_MS  = 500,
   parameter int RECOVER_MS   = 100,
   parameter int NEUTRAL_BAND = 10
) (
   input  logic       clk_255kHz,
   input  logic       reset,
   input  logic       valid_throttle,
   input  logic [7:0] throttle,
   input  logic       valid_steer,
   input  logic [7:0] steer,
   input  logic       valid_arm,
   input  logic [7:0] arm,
   input  logic       pause,
   output logic [7:0] width_left,
   output logic [7:0] width_right,
   output logic       armed,
   output logic       failsafe,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMING   = 2'd1,
      ST_ARMED    = 2'd2,
      ST_FAILSAFE = 2'd3
   } state_t;

   localparam int ARM_LIMIT = ARM_HOLD_MS * 255 - 1;
   localparam int REC_LIMIT = RECOVER_MS * 255 - 1;
   localparam int CNT_MAX   = (ARM_LIMIT > REC_LIMIT) ? ARM_LIMIT : REC_LIMIT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int PRE_W     = $clog2(SLEW_DIV);

   localparam logic [CNT_W-1:0]  ARM_END = CNT_W'(ARM_LIMIT);
   localparam logic [CNT_W-1:0]  REC_END = CNT_W'(REC_LIMIT);
   localparam logic [PRE_W-1:0]  PRE_END = PRE_W'(SLEW_DIV - 1);
   localparam logic signed [9:0] STEP    = 10'(SLEW_STEP);
   localparam logic signed [9:0] BAND    = 10'(NEUTRAL_BAND);
   localparam logic signed [9:0] MID     = 10'sd127;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [PRE_W-1:0]   r_pre;
   logic [7:0]         r_width_l;
   logic [7:0]         r_width_r;

   logic               w_all_valid;
   logic               w_arm_on;
   logic               w_arm_off;
   logic               w_neutral;
   logic               w_arm_cond;
   logic               w_fs_entry;
   logic               w_slew_tick;
   logic signed [9:0]  w_thr_s;
   logic signed [9:0]  w_str_s;
   logic signed [9:0]  w_thr_dev;
   logic [7:0]         w_tgt_l;
   logic [7:0]         w_tgt_r;

   function automatic logic [7:0] clamp8(input logic signed [9:0] v);
      logic [7:0] res;
      if (v < 10'sd0)        res = 8'd0;
      else if (v > 10'sd255) res = 8'd255;
      else                   res = v[7:0];
      return res;
   endfunction

   // Moves at most SLEW_STEP toward the target; the step is only taken when the gap
   // exceeds it, so the result can never wrap past 0 or 255.
   function automatic logic [7:0] slew8(input logic [7:0] cur, input logic [7:0] tgt);
      logic signed [9:0] d;
      logic [7:0]        res;
      d = signed'({2'b00, tgt}) - signed'({2'b00, cur});
      if (d <= STEP && d >= -STEP) res = tgt;
      else if (d > 10'sd0)         res = cur + 8'(SLEW_STEP);
      else                         res = cur - 8'(SLEW_STEP);
      return res;
   endfunction

   assign w_all_valid = valid_throttle & valid_steer & valid_arm;
   assign w_arm_on    = (arm >= 8'd192);
   assign w_arm_off   = (arm < 8'd64);
   assign w_thr_s     = signed'({2'b00, throttle});
   assign w_str_s     = signed'({2'b00, steer});
   assign w_thr_dev   = w_thr_s - MID;
   assign w_neutral   = (w_thr_dev <= BAND) && (w_thr_dev >= -BAND);
   assign w_arm_cond  = w_all_valid & w_arm_on & w_neutral;

   assign w_tgt_l = (r_state == ST_ARMED && !pause) ? clamp8(w_thr_s + w_str_s - MID) : 8'd127;
   assign w_tgt_r = (r_state == ST_ARMED && !pause) ? clamp8(w_thr_s - w_str_s + MID) : 8'd127;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_DISARMED: begin
            w_cnt_nxt = '0;
            if (w_arm_cond) w_state_nxt = ST_ARMING;
         end
         ST_ARMING: begin
            if (!w_arm_cond) begin
               w_state_nxt = ST_DISARMED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == ARM_END) begin
               w_state_nxt = ST_ARMED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_ARMED: begin
            w_cnt_nxt = '0;
            if (!w_all_valid)   w_state_nxt = ST_FAILSAFE;
            else if (w_arm_off) w_state_nxt = ST_DISARMED;
         end
         ST_FAILSAFE: begin
            if (!w_all_valid) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == REC_END) begin
               w_state_nxt = ST_DISARMED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_DISARMED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset) begin
         r_state <= ST_DISARMED;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_fs_entry  = (w_state_nxt == ST_FAILSAFE) && (r_state != ST_FAILSAFE);
   assign w_slew_tick = (r_pre == PRE_END);

   // Failsafe entry bypasses the limiter so the motors stop on the same edge.
   always_ff @(posedge clk_255kHz or posedge reset) begin
      if (reset) begin
         r_pre     <= '0;
         r_width_l <= 8'd127;
         r_width_r <= 8'd127;
      end else begin
         r_pre <= w_slew_tick ? '0 : r_pre + PRE_W'(1);
         if (w_fs_entry) begin
            r_width_l <= 8'd127;
            r_width_r <= 8'd127;
         end else if (w_slew_tick) begin
            r_width_l <= slew8(r_width_l, w_tgt_l);
            r_width_r <= slew8(r_width_r, w_tgt_r);
         end
      end
   end

   assign width_left  = r_width_l;
   assign width_right = r_width_r;
   assign armed       = (r_state == ST_ARMED);
   assign failsafe    = (r_state == ST_FAILSAFE);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_rc_drive_mixer.sv
// Directed bench for rc_drive_mixer: arming, hysteresis, ramps, clamping, pause,
// failsafe snap/recovery and asynchronous reset, checked through an expected-value queue.
module tb_rc_drive_mixer;

  localparam int SLEW_DIV = 255;
  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARMING = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_FS = 2'd3;
  localparam int W = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_throttle = 1'b1;
  logic [7:0] throttle = 8'd127;
  logic valid_steer = 1'b1;
  logic [7:0] steer = 8'd127;
  logic valid_arm = 1'b1;
  logic [7:0] arm_v = 8'd0;
  logic pause = 1'b0;
  logic [7:0] width_left;
  logic [7:0] width_right;
  logic armed;
  logic failsafe;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  string tag_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  rc_drive_mixer #(
    .SLEW_DIV(SLEW_DIV), .SLEW_STEP(4), .ARM_HOLD_MS(2), .RECOVER_MS(1), .NEUTRAL_BAND(10)
  ) dut (
    .clk_255kHz(clk), .reset(reset),
    .valid_throttle(valid_throttle), .throttle(throttle),
    .valid_steer(valid_steer), .steer(steer),
    .valid_arm(valid_arm), .arm(arm_v),
    .pause(pause),
    .width_left(width_left), .width_right(width_right),
    .armed(armed), .failsafe(failsafe), .dbg_state(dbg_state)
  );

  // clock / reset-relative edge counter (slew edges are where cyc becomes a multiple of SLEW_DIV)
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_slew();
    while (cyc % SLEW_DIV != 0) tick(1);
  endtask

  task automatic chk(input string tag, input logic [7:0] wl, input logic [7:0] wr,
                     input logic a, input logic f, input logic [1:0] st);
    exp_q.push_back({wl, wr, a, f, st});
    tag_q.push_back(tag);
  endtask

  // scoreboard monitor: compares every queued expectation at the next falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {width_left, width_right, armed, failsafe, dbg_state};
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got wl=%0d wr=%0d armed=%0b fs=%0b st=%0d, expected wl=%0d wr=%0d armed=%0b fs=%0b st=%0d",
                 t, act[19:12], act[11:4], act[3], act[2], act[1:0],
                 e[19:12], e[11:4], e[3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    chk("reset", 127, 127, 0, 0, S_DIS);
    tick(1);

    // arming hold, hysteresis abort, re-arm, hysteresis hold, arm_off
    arm_v = 8'd255;
    tick(200);
    chk("arming_mid", 127, 127, 0, 0, S_ARMING);
    arm_v = 8'd100;
    tick(1);
    chk("arm100_aborts", 127, 127, 0, 0, S_DIS);
    tick(2);
    arm_v = 8'd255;
    tick(510);
    chk("arm_hold_510", 127, 127, 0, 0, S_ARMING);
    tick(1);
    chk("armed_at_511", 127, 127, 1, 0, S_ARMED);
    arm_v = 8'd100;
    tick(5);
    chk("armed_hyst_100", 127, 127, 1, 0, S_ARMED);
    arm_v = 8'd50;
    tick(1);
    chk("arm_off_50", 127, 127, 0, 0, S_DIS);

    // neutral band
    throttle = 8'd200;
    arm_v = 8'd255;
    tick(600);
    chk("thr200_no_arm", 127, 127, 0, 0, S_DIS);
    throttle = 8'd135;
    tick(510);
    chk("thr135_arming", 127, 127, 0, 0, S_ARMING);
    tick(1);
    chk("thr135_armed", 127, 127, 1, 0, S_ARMED);
    throttle = 8'd127;

    // full-forward ramp
    sync_slew();
    throttle = 8'd255;
    tick(255);
    chk("ramp_t1", 131, 131, 1, 0, S_ARMED);
    tick(255);
    chk("ramp_t2", 135, 135, 1, 0, S_ARMED);
    tick(255 * 29);
    chk("ramp_t31", 251, 251, 1, 0, S_ARMED);
    tick(255);
    chk("ramp_t32", 255, 255, 1, 0, S_ARMED);
    tick(510);
    chk("ramp_hold", 255, 255, 1, 0, S_ARMED);

    // full steer: left clamps at 255, right returns to 127
    sync_slew();
    steer = 8'd255;
    tick(255);
    chk("steer_t1", 255, 251, 1, 0, S_ARMED);
    tick(255 * 31);
    chk("steer_t32", 255, 127, 1, 0, S_ARMED);

    // reverse + full steer: left 128, right clamps to 0
    sync_slew();
    throttle = 8'd0;
    tick(255);
    chk("rev_t1", 251, 123, 1, 0, S_ARMED);
    tick(255 * 30);
    chk("rev_t31", 131, 3, 1, 0, S_ARMED);
    tick(255);
    chk("rev_t32_snap", 128, 0, 1, 0, S_ARMED);
    tick(255);
    chk("rev_floor_hold", 128, 0, 1, 0, S_ARMED);

    // pause slews toward neutral without disarming
    sync_slew();
    pause = 1'b1;
    tick(255);
    chk("pause", 127, 4, 1, 0, S_ARMED);
    pause = 1'b0;

    // failsafe snap and recovery
    throttle = 8'd200;
    steer = 8'd127;
    tick(255 * 19);
    chk("pre_failsafe", 200, 80, 1, 0, S_ARMED);
    valid_steer = 1'b0;
    tick(1);
    chk("fs_snap", 127, 127, 0, 1, S_FS);
    tick(3);
    valid_steer = 1'b1;
    tick(254);
    chk("fs_hold_254", 127, 127, 0, 1, S_FS);
    tick(1);
    chk("fs_recover", 127, 127, 0, 0, S_DIS);

    // re-arm, then invalid+arm_off together (failsafe wins), glitch restarts recovery
    throttle = 8'd127;
    tick(511);
    chk("rearm", 127, 127, 1, 0, S_ARMED);
    valid_arm = 1'b0;
    arm_v = 8'd0;
    tick(1);
    chk("fs_priority", 127, 127, 0, 1, S_FS);
    valid_arm = 1'b1;
    tick(100);
    valid_arm = 1'b0;
    tick(1);
    valid_arm = 1'b1;
    tick(254);
    chk("fs_glitch_hold", 127, 127, 0, 1, S_FS);
    tick(1);
    chk("fs_glitch_recover", 127, 127, 0, 0, S_DIS);

    // asynchronous reset mid-ramp
    arm_v = 8'd255;
    tick(511);
    chk("rearm2", 127, 127, 1, 0, S_ARMED);
    sync_slew();
    throttle = 8'd255;
    tick(255 * 3);
    chk("ramp_pre_reset", 139, 139, 1, 0, S_ARMED);
    tick(7);
    reset = 1'b1;
    chk("reset_async", 127, 127, 0, 0, S_DIS);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("post_reset_dis", 127, 127, 0, 0, S_DIS);

    // arm_off leaves widths to slew, no snap
    throttle = 8'd127;
    tick(511);
    chk("rearm3", 127, 127, 1, 0, S_ARMED);
    sync_slew();
    throttle = 8'd255;
    tick(510);
    chk("ramp_pre_off", 135, 135, 1, 0, S_ARMED);
    arm_v = 8'd50;
    tick(1);
    chk("arm_off_no_snap", 135, 135, 0, 0, S_DIS);
    tick(254);
    chk("arm_off_slews", 131, 131, 0, 0, S_DIS);

    // final report
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick(1);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
